// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//   UART receive engine: a 2-flop input synchroniser, a 3-sample majority vote
//   at each bit centre, a configurable character length and stop-bit count,
//   framing/parity error flags and a one-entry output register with overrun
//   detection.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (f_clk / baud), >= 8
//   DATA_BITS     character length 5..9, received LSB first
//   STOP_BITS     stop bits checked, 1 or 2
//   PARITY_ODD    parity sense when parity is compiled in (0 even, 1 odd)
//
// Compile-time option
//   UART_RX_PARITY_EN  when defined, one parity bit follows the data bits and
//                      parity_err reports a mismatch; otherwise no parity bit
//                      is expected and parity_err is tied low.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   serial_in   asynchronous serial line, idle high
//   rx_data     received character, valid while rx_valid = 1
//   rx_valid    holding register full
//   rx_ready    consumer accepts rx_data
//   frame_err   a stop bit was sampled 0 (qualified by rx_valid)
//   parity_err  parity mismatch (qualified by rx_valid)
//   overrun     one-cycle pulse when a completed frame is dropped
//
// Handshake: rx_data/frame_err/parity_err are transferred on every rising clk
// edge where rx_valid & rx_ready are both 1. rx_valid stays high, with the
// payload stable, until that transfer. A frame completing in the same cycle as
// a transfer reloads the register; a frame completing while the register is
// full and not being read is discarded and flagged on overrun.
// -----------------------------------------------------------------------------
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 50,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int MID = CLKS_PER_BIT / 2;
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] SAMP_A   = CW'(MID - 1);
  localparam logic [CW-1:0] SAMP_B   = CW'(MID);
  localparam logic [CW-1:0] SAMP_C   = CW'(MID + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // FSM state is kept as a plain named signal so checkers can bind to it.
  state_t                 state;
  logic                   sync1;
  logic                   s_in;
  logic [CW-1:0]          cnt;
  logic                   samp0;
  logic                   samp1;
  logic [BW-1:0]          bit_idx;
  logic                   stop_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   ferr_acc;
`ifdef UART_RX_PARITY_EN
  logic                   perr_acc;
`endif

  logic decide;
  logic voted;
  logic stop_fe;

  // The third sample is the live s_in at the decision cycle.
  assign decide  = (cnt == SAMP_C);
  assign voted   = (samp0 & samp1) | (samp0 & s_in) | (samp1 & s_in);
  assign stop_fe = ferr_acc | ~voted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sync1      <= 1'b1;
      s_in       <= 1'b1;
      cnt        <= '0;
      samp0      <= 1'b1;
      samp1      <= 1'b1;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      ferr_acc   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_acc   <= 1'b0;
`endif
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sync1   <= serial_in;
      s_in    <= sync1;
      overrun <= 1'b0;

      if (cnt == SAMP_A) samp0 <= s_in;
      if (cnt == SAMP_B) samp1 <= s_in;

      // Consumer read; a completing frame below overrides this with a reload.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (state == IDLE)        cnt <= '0;
      else if (cnt == CNT_LAST) cnt <= '0;
      else                      cnt <= cnt + 1'b1;

      case (state)
        IDLE: begin
          if (!s_in) begin
            state <= START;
            cnt   <= CW'(1);
          end
        end

        START: begin
          if (decide) begin
            if (voted) begin
              // Start bit did not survive the vote: treat as a glitch.
              state <= IDLE;
              cnt   <= '0;
            end else begin
              state    <= DATA;
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              ferr_acc <= 1'b0;
            end
          end
        end

        DATA: begin
          if (decide) begin
            shreg <= {voted, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (decide) begin
            perr_acc <= ((^shreg) ^ voted) != PARITY_ODD[0];
            state    <= STOP;
          end
        end
`endif

        STOP: begin
          if (decide) begin
            if (stop_idx == LAST_STOP) begin
              // Back to IDLE mid-bit so the next start edge is caught early.
              state <= IDLE;
              cnt   <= '0;
              if (!rx_valid || rx_ready) begin
                rx_data   <= shreg;
                frame_err <= stop_fe;
`ifdef UART_RX_PARITY_EN
                parity_err <= perr_acc;
`else
                parity_err <= 1'b0;
`endif
                rx_valid  <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              stop_idx <= 1'b1;
              ferr_acc <= stop_fe;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
//   Directed bench for uart_rx_core at CLKS_PER_BIT = 16, 8 data bits, 1 stop
//   bit. A cycle-level reference predicts when each frame completes from the
//   documented latency and applies the output-register delivery rules; a
//   compare process checks every cycle, and the directed sequence pins the
//   delivered characters and flags against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

  localparam int C    = 16;
  localparam int D    = 8;
  localparam int S    = 1;
  localparam int PODD = 0;
  localparam int MID  = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int N = D + P + S;
  localparam int W = D + 2;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         serial_in = 1'b1;
  logic         rx_ready = 1'b1;
  logic [D-1:0] rx_data;
  logic         rx_valid;
  logic         frame_err;
  logic         parity_err;
  logic         overrun;

  always #5 clk = ~clk;

  uart_rx_core #(
    .CLKS_PER_BIT(C),
    .DATA_BITS   (D),
    .STOP_BITS   (S),
    .PARITY_ODD  (PODD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int bit_start_cyc   = 0;
  int frame_start_cyc = 0;
  int ovr_cnt  = 0;

  logic [W-1:0] exp_q[$];     // {parity_err, frame_err, data} per frame
  int           ev_q[$];      // cycle at which each frame completes
  logic [W-1:0] got_q[$];     // payloads accepted by the consumer
  int           got_cyc_q[$];

  logic         m_valid = 1'b0;
  logic         m_ovr   = 1'b0;
  logic         m_fe    = 1'b0;
  logic         m_pe    = 1'b0;
  logic [D-1:0] m_data  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  always @(posedge clk) begin
    logic [W-1:0] e;
    cyc++;
    m_ovr = 1'b0;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_fe    = 1'b0;
      m_pe    = 1'b0;
    end else if (ev_q.size() > 0 && ev_q[0] == cyc) begin
      void'(ev_q.pop_front());
      e = exp_q.pop_front();
      if (!m_valid || rx_ready) begin
        {m_pe, m_fe, m_data} = e;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rx_ready) begin
      m_valid = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #3;
    chk("rx_valid", {31'd0, rx_valid}, {31'd0, m_valid});
    chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    if (m_valid) begin
      chk("rx_data", 32'(rx_data), 32'(m_data));
      chk("frame_err", {31'd0, frame_err}, {31'd0, m_fe});
      chk("parity_err", {31'd0, parity_err}, {31'd0, m_pe});
    end
    if (overrun) ovr_cnt++;
  end

  // Record what the consumer actually takes, for the directed checks.
  always @(negedge clk) begin
    #1;
    if (rx_valid && rx_ready) begin
      got_q.push_back({parity_err, frame_err, rx_data});
      got_cyc_q.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic b, input logic flip);
    for (int i = 0; i < C; i++) begin
      @(negedge clk);
      if (i == 0) bit_start_cyc = cyc;
      serial_in = (flip && i == MID) ? ~b : b;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      serial_in = 1'b1;
    end
  endtask

  task automatic glitch(input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      serial_in = 1'b0;
    end
    @(negedge clk);
    serial_in = 1'b1;
  endtask

  task automatic send_frame(input logic [D-1:0] d, input logic par_inv,
                            input logic stop_val, input logic flip);
    logic [D-1:0] dv;
    logic pb;
    dv = d;
    drive_bit(1'b0, 1'b0);
    frame_start_cyc = bit_start_cyc;
    ev_q.push_back(bit_start_cyc + 4 + MID + N * C);
    exp_q.push_back({(P == 1) ? par_inv : 1'b0, ~stop_val, dv});
    for (int i = 0; i < D; i++) drive_bit(dv[i], flip);
    if (P == 1) begin
      pb = (^dv) ^ PODD[0] ^ par_inv;
      drive_bit(pb, 1'b0);
    end
    for (int i = 0; i < S; i++) drive_bit(stop_val, 1'b0);
  endtask

  task automatic expect_one(input string name, input logic [D-1:0] d,
                            input logic fe, input logic pe);
    logic [W-1:0] g;
    checks++;
    if (got_q.size() == 0) begin
      failures++;
      $display("FAIL %s: no character accepted, expected %0h", name, d);
    end else begin
      g = got_q.pop_front();
      void'(got_cyc_q.pop_front());
      chk({name, "_data"}, 32'(g[D-1:0]), 32'(d));
      chk({name, "_fe"}, {31'd0, g[D]}, {31'd0, fe});
      chk({name, "_pe"}, {31'd0, g[D+1]}, {31'd0, pe});
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int exp_lat;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_data", 32'(rx_data), 32'd0);
    chk("reset_fe", {31'd0, frame_err}, 32'd0);
    chk("reset_pe", {31'd0, parity_err}, 32'd0);
    chk("reset_ovr", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    // Plain character, consumer always ready; latency 4 + 8 + 16*N.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    idle(2 * C);
`ifdef UART_RX_PARITY_EN
    exp_lat = 172;
`else
    exp_lat = 156;
`endif
    if (got_cyc_q.size() > 0) begin
      lat = got_cyc_q[0] - frame_start_cyc;
      chk("a5_latency", 32'(lat), 32'(exp_lat));
    end
    expect_one("a5", 8'hA5, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
    // 0x55 has four ones: even parity bit 0 is correct, 1 is a mismatch.
    send_frame(8'h55, 1'b0, 1'b1, 1'b0);
    idle(2 * C);
    expect_one("par_ok", 8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b1, 1'b1, 1'b0);
    idle(2 * C);
    expect_one("par_bad", 8'h55, 1'b0, 1'b1);
`endif

    // Framing error is delivered, and does not stick to the next frame.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    idle(2 * C);
    expect_one("ferr", 8'h3C, 1'b1, 1'b0);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    idle(2 * C);
    expect_one("after_ferr", 8'h81, 1'b0, 1'b0);

    // Short low pulses must not produce output.
    glitch(1);
    idle(2 * C);
    glitch(3);
    idle(2 * C);
    chk("glitch_no_output", 32'(got_q.size()), 32'd0);

    // One inverted sample at every data-bit centre is outvoted.
    send_frame(8'h0F, 1'b0, 1'b1, 1'b1);
    idle(2 * C);
    expect_one("vote", 8'h0F, 1'b0, 1'b0);

    // Overrun: second frame dropped while the first is held.
    @(negedge clk);
    rx_ready = 1'b0;
    ovr_cnt  = 0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    idle(C);
    chk("ovr_count", 32'(ovr_cnt), 32'd1);
    chk("ovr_held_valid", {31'd0, rx_valid}, 32'd1);
    chk("ovr_held_data", 32'(rx_data), 32'h11);
    @(negedge clk);
    rx_ready = 1'b1;
    @(posedge clk);
    #3;
    chk("ovr_valid_drop", {31'd0, rx_valid}, 32'd0);
    expect_one("ovr_first", 8'h11, 1'b0, 1'b0);
    chk("ovr_no_extra", 32'(got_q.size()), 32'd0);

    // Reset in the middle of data bit 4 of 0xFF, with a character held.
    @(negedge clk);
    rx_ready = 1'b0;
    send_frame(8'h33, 1'b0, 1'b1, 1'b0);
    idle(C);
    chk("pre_rst_valid", {31'd0, rx_valid}, 32'd1);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
    for (int i = 0; i < MID; i++) begin
      @(negedge clk);
      serial_in = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_fe", {31'd0, frame_err}, 32'd0);
    chk("rst_pe", {31'd0, parity_err}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rx_ready = 1'b1;
    idle(4);
    send_frame(8'h42, 1'b0, 1'b1, 1'b0);
    idle(2 * C);
    expect_one("post_rst", 8'h42, 1'b0, 1'b0);
    chk("no_stray_output", 32'(got_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
